key_press_pulser: RTL and testbench



---
 rtl/key_press_pulser_pkg.sv | 18 +
 rtl/key_press_pulser_if.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/key_press_pulser.sv | 90 +++++++++
 tb/tb_key_press_pulser.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/key_press_pulser_pkg.sv
// Shared constants for the tug-of-war input conditioning path.
// State encodings and key polarity helpers.
package game_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESS_CHK = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] REL_CHK   = 2'd3;

    localparam bit   ACTIVE_LOW_DEF   = 1'b1;
    localparam logic KEY_RELEASED_LVL = ACTIVE_LOW_DEF;

    // Raw level a released key reads for a given polarity.
    function automatic logic released_lvl(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/key_press_pulser_if.sv
// Key input and conditioned outputs of one player pushbutton.
// The master drives the raw key; the slave returns strobe and level.
interface key_press_pulser_if;

    logic Key;
    logic Increase;
    logic Held;

    modport master (
        output Key,
        input  Increase,
        input  Held
    );

    modport slave (
        input  Key,
        output Increase,
        output Held
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Reset value is a parameter so idle levels survive reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/key_press_pulser.sv
// Synchronizes and debounces one pushbutton, emitting one
// Increase strobe per accepted press plus a Held level.
module key_press_pulser
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic         Clock,
    input  logic         Reset,
    key_press_pulser_if.slave kp
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          w_sync;
    logic          w_pressed;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_inc;
    logic          r_held;

    sync_2ff #(
        .RST_VAL (released_lvl(ACTIVE_LOW))
    ) u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d     (kp.Key),
        .q     (w_sync)
    );

    assign w_pressed = w_sync ^ ACTIVE_LOW;

    // Counter is cleared on every state entry, so it never wraps.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_inc   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_inc <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_pressed) begin
                        r_state <= PRESS_CHK;
                        r_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!w_pressed) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_inc   <= 1'b1;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!w_pressed) begin
                        r_state <= REL_CHK;
                        r_cnt   <= '0;
                    end
                end
                REL_CHK: begin
                    if (w_pressed) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign kp.Increase = r_inc;
    assign kp.Held     = r_held;

endmodule

// File: tb/tb_key_press_pulser.sv
// Directed bench for key_press_pulser with a run-length debounce model.
// Two instances: default (4, active-low) and (1, active-high).
module tb_key_press_pulser;

    logic Clock;
    logic Reset;

    key_press_pulser_if ifA ();
    key_press_pulser_if ifB ();

    key_press_pulser #(
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dutA (
        .Clock (Clock),
        .Reset (Reset),
        .kp    (ifA)
    );

    key_press_pulser #(
        .DEBOUNCE_CYCLES (1),
        .ACTIVE_LOW      (1'b0)
    ) dutB (
        .Clock (Clock),
        .Reset (Reset),
        .kp    (ifB)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Model: accepted level flips after d+1 consecutive differing samples.
    typedef struct {
        bit s1;
        bit s2;
        bit acc;
        bit inc;
        int run;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, bit rst, bit key, bit al, int d);
        mdl_t n;
        n = m;
        if (rst) begin
            n.s1  = 1'b0;
            n.s2  = 1'b0;
            n.acc = 1'b0;
            n.inc = 1'b0;
            n.run = 0;
            return n;
        end
        n.inc = 1'b0;
        if (m.s2 != m.acc) begin
            n.run = m.run + 1;
            if (n.run == d + 1) begin
                n.acc = !m.acc;
                n.run = 0;
                n.inc = n.acc;
            end
        end else begin
            n.run = 0;
        end
        n.s2 = m.s1;
        n.s1 = key ^ al;
        return n;
    endfunction

    mdl_t mA;
    mdl_t mB;
    int   cyc = 0;

    always @(posedge Clock) begin
        mA = step(mA, Reset, ifA.Key, 1'b1, 4);
        mB = step(mB, Reset, ifB.Key, 1'b0, 1);
        cyc++;
    end

    int total = 0;
    int pass  = 0;
    int npa   = 0;
    bit sc    = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d",
                      nm, cyc, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge Clock);
            chk("A_inc_model", 32'(ifA.Increase), 32'(mA.inc));
            chk("A_held_model", 32'(ifA.Held), 32'(mA.acc));
            chk("B_inc_model", 32'(ifB.Increase), 32'(mB.inc));
            chk("B_held_model", 32'(ifB.Held), 32'(mB.acc));
            if (ifA.Increase === 1'b1) begin
                npa++;
                sc ^= 1'b1;
            end
        end
    endtask

    int t0;
    int n0;

    initial begin
        Reset   = 1'b1;
        ifA.Key = 1'b0;
        ifB.Key = 1'b0;

        // Reset with key pressed, then one pulse 7 edges later
        tick(3);
        chk("rst_inc", 32'(ifA.Increase), 0);
        chk("rst_held", 32'(ifA.Held), 0);
        Reset = 1'b0;
        tick(6);
        chk("postrst_inc_early", 32'(ifA.Increase), 0);
        tick(1);
        chk("postrst_inc_e7", 32'(ifA.Increase), 1);
        chk("postrst_held", 32'(ifA.Held), 1);
        ifA.Key = 1'b1;
        tick(15);
        chk("postrst_released", 32'(ifA.Held), 0);

        // Clean press
        t0 = cyc;
        ifA.Key = 1'b0;
        tick(6);
        chk("clean_inc_e6", 32'(ifA.Increase), 0);
        tick(1);
        chk("clean_inc_e7", 32'(ifA.Increase), 1);
        tick(1);
        chk("clean_inc_e8", 32'(ifA.Increase), 0);
        tick(12);
        ifA.Key = 1'b1;
        tick(6);
        chk("clean_held_rel6", 32'(ifA.Held), 1);
        tick(1);
        chk("clean_held_rel7", 32'(ifA.Held), 0);
        tick(5);

        // Press bounce rejected
        n0 = npa;
        ifA.Key = 1'b0; tick(3);
        ifA.Key = 1'b1; tick(1);
        ifA.Key = 1'b0; tick(3);
        ifA.Key = 1'b1; tick(10);
        chk("pbounce_pulses", 32'(npa - n0), 0);
        chk("pbounce_held", 32'(ifA.Held), 0);

        // Release bounce rejected
        n0 = npa;
        ifA.Key = 1'b0; tick(10);
        for (int i = 0; i < 5; i++) begin
            ifA.Key = ~ifA.Key;
            tick(2);
        end
        ifA.Key = 1'b0; tick(10);
        chk("rbounce_pulses", 32'(npa - n0), 1);
        chk("rbounce_held", 32'(ifA.Held), 1);
        ifA.Key = 1'b1; tick(10);
        chk("rbounce_release", 32'(ifA.Held), 0);

        // Two presses into a 1-bit score counter
        n0 = npa;
        sc = 1'b0;
        ifA.Key = 1'b0; tick(10);
        ifA.Key = 1'b1; tick(12);
        ifA.Key = 1'b0; tick(10);
        ifA.Key = 1'b1; tick(12);
        chk("two_pulses", 32'(npa - n0), 2);
        chk("score_bit", 32'(sc), 0);

        // Reset lands on the would-be pulse edge
        ifA.Key = 1'b0;
        tick(6);
        Reset = 1'b1;
        tick(1);
        chk("rstpulse_inc", 32'(ifA.Increase), 0);
        chk("rstpulse_held", 32'(ifA.Held), 0);
        Reset = 1'b0;
        tick(6);
        chk("rstpulse_early", 32'(ifA.Increase), 0);
        tick(1);
        chk("rstpulse_e7", 32'(ifA.Increase), 1);
        ifA.Key = 1'b1;
        tick(12);

        // Variant D=1, active-high
        ifB.Key = 1'b1;
        tick(3);
        chk("B_inc_e3", 32'(ifB.Increase), 0);
        tick(1);
        chk("B_inc_e4", 32'(ifB.Increase), 1);
        tick(1);
        chk("B_inc_e5", 32'(ifB.Increase), 0);
        chk("B_held", 32'(ifB.Held), 1);
        ifB.Key = 1'b0;
        tick(6);
        chk("B_released", 32'(ifB.Held), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
